mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arb_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory line-port arbiter: FSM encoding, owner ids, line geometry.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int LINE_BITS_DEF = 128;
  localparam int LINE_OFF_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_e;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

endpackage

// File: rtl/mem_port_arb_pick.sv
// Combinational winner select between icache and dcache requests.
// MEM_PORT_ARBITER_RR_EN: alternate on contention using lastOwner; otherwise dcache always wins.
module mem_port_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic icReq,
  input  logic dcReq,
`ifdef MEM_PORT_ARBITER_RR_EN
  input  logic lastOwner,
`endif
  output logic grantVld,
  output logic grantOwner
);

  always_comb begin
    grantVld   = icReq | dcReq;
    grantOwner = OWNER_IC;
    if (icReq && dcReq) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      grantOwner = ~lastOwner;
`else
      grantOwner = OWNER_DC;
`endif
    end else if (dcReq) begin
      grantOwner = OWNER_DC;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory line port between icache and dcache; done pulses L+2 cycles after grant (L = memory latency).
// Requests held by the owner wait while busy, no preemption; MEM_PORT_ARBITER_RR_EN selects round-robin priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int LINE_OFF  = LINE_OFF_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [ADDR_W-1:0]    ic_addr,
  output logic                 ic_done,
  output logic [LINE_BITS-1:0] ic_rdata,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic                 dc_done,
  output logic [LINE_BITS-1:0] dc_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [LINE_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic                 owner
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << LINE_OFF;

  arbState_e state, stateNxt;
  logic      grantVld, grantOwner;
  logic      grantNow;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic      lastOwner;
`endif

  mem_port_arb_pick uPick (
    .icReq      (ic_req),
    .dcReq      (dc_req),
`ifdef MEM_PORT_ARBITER_RR_EN
    .lastOwner  (lastOwner),
`endif
    .grantVld   (grantVld),
    .grantOwner (grantOwner)
  );

  // Requests are only looked at in IDLE, so a requester dropping req right after done is never re-granted.
  assign grantNow = (state == IDLE) && grantVld;

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (grantVld) stateNxt = ISSUE;
      ISSUE:   stateNxt = WAIT;
      WAIT:    if (mem_rvalid) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
      owner     <= OWNER_IC;
    end else begin
      state   <= stateNxt;
      busy    <= (stateNxt != IDLE);
      mem_req <= (stateNxt == ISSUE);
      ic_done <= (stateNxt == DONE) && (owner == OWNER_IC);
      dc_done <= (stateNxt == DONE) && (owner == OWNER_DC);

      if (grantNow) begin
        owner <= grantOwner;
        if (grantOwner == OWNER_DC) begin
          mem_addr  <= dc_addr & ALIGN_MASK;
          mem_we    <= dc_we;
          mem_wdata <= dc_wdata;
        end else begin
          mem_addr  <= ic_addr & ALIGN_MASK;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
        end
      end

      // Write acks carry no data; only read completions update the owner's line.
      if ((state == WAIT) && mem_rvalid && !mem_we) begin
        if (owner == OWNER_IC) ic_rdata <= mem_rdata;
        else                   dc_rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_PORT_ARBITER_RR_EN
  always_ff @(posedge clk) begin
    if (!rst)          lastOwner <= OWNER_DC;
    else if (grantNow) lastOwner <= grantOwner;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req, dc_req, dc_we, mem_rvalid;
  logic [31:0]  ic_addr, dc_addr;
  logic [127:0] dc_wdata, mem_rdata;
  logic         ic_done, dc_done, mem_req, mem_we, busy, owner;
  logic [127:0] ic_rdata, dc_rdata, mem_wdata;
  logic [31:0]  mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  localparam logic [127:0] LINE_A   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] LINE_B   = 128'h0BB0B0B0_22223333_44445555_66667777;
  localparam logic [127:0] LINE_BAD = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
  localparam logic [127:0] LINE_C   = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] LINE_D   = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
  localparam logic [127:0] LINE_E   = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
  localparam logic [127:0] LINE_F   = 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3;
  localparam logic [127:0] WB_LINE  = 128'h11111111_11111111_11111111_11111111;

  int nCmp = 0;
  int nErr = 0;
  int cyc  = 0;

  always @(posedge clk) cyc++;

  task automatic check1(input string name, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic checkW(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkI(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory responder: answers each mem_req strobe memLat cycles later with respData.
  int           memLat   = 1;
  int           pend     = 0;
  logic [127:0] respData = '0;

  always @(posedge clk) begin
    logic sawReq;
    sawReq = (mem_req === 1'b1);
    #2;
    mem_rvalid = 1'b0;
    if (sawReq) pend = memLat;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = respData;
      end
    end
  end

  // Reference model: one transaction at a time, tracked by how far it has progressed.
  // txnStep: 0 no transaction, 1 request strobe cycle, 2 awaiting response, 3 completion cycle.
  int           txnStep = 0;
  logic         mBusy = 0, mOwner = 0, mLast = 1, mWe = 0;
  logic         mMemReq = 0, mIcDone = 0, mDcDone = 0;
  logic [31:0]  mAddr = '0;
  logic [127:0] mWdata = '0, mIcData = '0, mDcData = '0;

  always @(posedge clk) begin
    logic w;
    mMemReq = 1'b0;
    mIcDone = 1'b0;
    mDcDone = 1'b0;
    if (rst !== 1'b1) begin
      txnStep = 0; mBusy = 0; mOwner = 0; mLast = 1; mWe = 0;
      mAddr = '0; mWdata = '0; mIcData = '0; mDcData = '0;
    end else begin
      case (txnStep)
        0: if (ic_req || dc_req) begin
`ifdef MEM_PORT_ARBITER_RR_EN
             w = (ic_req && dc_req) ? ~mLast : dc_req;
`else
             w = dc_req;
`endif
             mOwner  = w;
             mLast   = w;
             mAddr   = (w ? dc_addr : ic_addr) & 32'hFFFF_FFF0;
             mWe     = w ? dc_we : 1'b0;
             mWdata  = w ? dc_wdata : '0;
             mBusy   = 1'b1;
             mMemReq = 1'b1;
             txnStep = 1;
           end
        1: txnStep = 2;
        2: if (mem_rvalid) begin
             if (!mWe) begin
               if (mOwner) mDcData = mem_rdata;
               else        mIcData = mem_rdata;
             end
             if (mOwner) mDcDone = 1'b1;
             else        mIcDone = 1'b1;
             txnStep = 3;
           end
        default: begin
          mBusy   = 1'b0;
          txnStep = 0;
        end
      endcase
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check1("busy", busy, mBusy);
      check1("owner", owner, mOwner);
      check1("mem_req", mem_req, mMemReq);
      check1("ic_done", ic_done, mIcDone);
      check1("dc_done", dc_done, mDcDone);
      checkW("ic_rdata", ic_rdata, mIcData);
      checkW("dc_rdata", dc_rdata, mDcData);
      if (mMemReq) begin
        checkW("mem_addr", {96'd0, mem_addr}, {96'd0, mAddr});
        check1("mem_we", mem_we, mWe);
        checkW("mem_wdata", mem_wdata, mWdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // which: 0 ic_done, 1 dc_done, 2 mem_req. Returns the cycle index of the hit.
  task automatic waitSig(input int which, input string name, output int hitCyc);
    bit hit;
    int budget;
    hit    = 0;
    budget = 40;
    hitCyc = -1;
    while (!hit && budget > 0) begin
      @(negedge clk);
      case (which)
        0:       hit = (ic_done === 1'b1);
        1:       hit = (dc_done === 1'b1);
        default: hit = (mem_req === 1'b1);
      endcase
      budget--;
    end
    if (hit) hitCyc = cyc;
    else begin
      nCmp++;
      nErr++;
      $display("FAIL timeout %s: no pulse within 40 cycles", name);
    end
  endtask

  initial begin
    int g, r, d, e;
    int order[4];
    bit sawDone, sawBusy;
    int rvCount;

    rst = 1'b0; ic_req = 1'b1; ic_addr = 32'h1234_5678;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    memLat = 2; respData = LINE_A;

    // Reset held two edges with a request pending.
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check1("rst busy", busy, 1'b0);
    check1("rst mem_req", mem_req, 1'b0);
    check1("rst owner", owner, 1'b0);
    checkW("rst mem_addr", {96'd0, mem_addr}, 128'd0);
    checkW("rst ic_rdata", ic_rdata, 128'd0);
    g = cyc;
    waitSig(2, "post-reset issue", r);
    checkI("post-reset issue delay", r - g, 1);
    checkW("post-reset mem_addr", {96'd0, mem_addr}, 128'h1234_5670);
    waitSig(0, "post-reset ic_done", d);
    tick(); ic_req = 1'b0;

    // Single icache read, latency 5.
    tick();
    ic_addr = 32'h0000_1234; ic_req = 1'b1; memLat = 5; respData = LINE_A;
    g = cyc;
    waitSig(2, "ic issue", r);
    checkI("ic issue delay", r - g, 1);
    checkW("ic mem_addr", {96'd0, mem_addr}, 128'h1230);
    waitSig(0, "ic done", d);
    checkI("ic done delay", d - g, 7);
    checkW("ic line", ic_rdata, LINE_A);
    check1("ic no dc_done", dc_done, 1'b0);
    tick(); ic_req = 1'b0;
    @(negedge clk);
    check1("ic done one cycle", ic_done, 1'b0);

    // Dcache read alone, latency 1.
    tick();
    dc_addr = 32'h2000; dc_we = 1'b0; dc_req = 1'b1; memLat = 1; respData = LINE_B;
    g = cyc;
    waitSig(1, "dc read done", d);
    checkI("dc read done delay", d - g, 3);
    checkW("dc read line", dc_rdata, LINE_B);
    checkW("ic line kept", ic_rdata, LINE_A);
    tick(); dc_req = 1'b0;

    // Dcache writeback; the ack data must not land in dc_rdata.
    tick();
    dc_addr = 32'h3008; dc_we = 1'b1; dc_wdata = WB_LINE; dc_req = 1'b1;
    memLat = 3; respData = LINE_BAD;
    g = cyc;
    waitSig(2, "wb issue", r);
    check1("wb mem_we", mem_we, 1'b1);
    checkW("wb mem_addr", {96'd0, mem_addr}, 128'h3000);
    checkW("wb mem_wdata", mem_wdata, WB_LINE);
    waitSig(1, "wb done", d);
    checkI("wb done delay", d - g, 5);
    checkW("wb dc_rdata unchanged", dc_rdata, LINE_B);
    tick(); dc_req = 1'b0; dc_we = 1'b0;

`ifndef MEM_PORT_ARBITER_RR_EN
    // Contention: dcache wins; icache is granted in the IDLE cycle after dc_done.
    tick();
    ic_addr = 32'h1234; dc_addr = 32'h2000; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1; memLat = 2; respData = LINE_C;
    g = cyc;
    waitSig(2, "contend first issue", r);
    check1("contend first owner", owner, 1'b1);
    checkW("contend first addr", {96'd0, mem_addr}, 128'h2000);
    waitSig(1, "contend dc done", d);
    checkI("contend dc done delay", d - g, 4);
    tick(); dc_req = 1'b0; respData = LINE_D;
    waitSig(2, "contend second issue", e);
    checkI("contend ic issue after dc_done", e - d, 2);
    check1("contend second owner", owner, 1'b0);
    checkW("contend second addr", {96'd0, mem_addr}, 128'h1230);
    waitSig(0, "contend ic done", d);
    checkW("contend ic line", ic_rdata, LINE_D);
    checkW("contend dc line", dc_rdata, LINE_C);
    tick(); ic_req = 1'b0;
`else
    // Round-robin: after reset both held for four transactions alternate icache first.
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    ic_addr = 32'h1234; dc_addr = 32'h2000; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1; memLat = 1; respData = LINE_E;
    for (int i = 0; i < 4; i++) begin
      waitSig(2, "rr issue", r);
      order[i] = int'(owner);
    end
    waitSig(1, "rr last done", d);
    tick(); ic_req = 1'b0; dc_req = 1'b0;
    checkI("rr grant 0", order[0], 0);
    checkI("rr grant 1", order[1], 1);
    checkI("rr grant 2", order[2], 0);
    checkI("rr grant 3", order[3], 1);
`endif

    // Reset two cycles after the strobe; the late response must be dropped.
    tick();
    ic_addr = 32'h4448; ic_req = 1'b1; memLat = 6; respData = LINE_F;
    waitSig(2, "rstwait issue", r);
    tick();
    tick(); rst = 1'b0; ic_req = 1'b0;
    tick(); rst = 1'b1;
    sawDone = 0; sawBusy = 0; rvCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ic_done === 1'b1 || dc_done === 1'b1) sawDone = 1;
      if (busy !== 1'b0) sawBusy = 1;
      if (mem_rvalid === 1'b1) rvCount++;
    end
    checkI("rstwait stale response seen", rvCount, 1);
    check1("rstwait no done", sawDone, 1'b0);
    check1("rstwait idle", sawBusy, 1'b0);
    checkW("rstwait ic_rdata cleared", ic_rdata, 128'd0);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
